// File: rtl/perm_seq_ctrl_if.sv
// Handshake bundle for the permutation sequencer: input state offer and
// permuted-state delivery, each with a valid/ready pair.
interface perm_seq_ctrl_if #(
  parameter int unsigned X_AXIS = 5,
  parameter int unsigned Y_AXIS = 5,
  parameter int unsigned Z_AXIS = 64
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] in_state;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] out_state;

  // Producer/consumer side
  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  // Controller side
  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/perm_seq_ctrl.sv
// Permutation sequencer: accepts a state, steps an external registered
// datapath through NUM_STAGES passes (3 rounds each), then presents the
// result until the consumer takes it. Counts completed permutations.
module perm_seq_ctrl #(
  parameter int unsigned X_AXIS     = 5,
  parameter int unsigned Y_AXIS     = 5,
  parameter int unsigned Z_AXIS     = 64,
  parameter int unsigned NUM_STAGES = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  perm_seq_ctrl_if.slave                            bus,
  output logic                                      stage_en,
  output logic [31:0]                               perm_stage,
  output logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] stage_in,
  input  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] stage_out,
  output logic                                      busy,
  output logic [15:0]                               perm_cnt
);

  localparam int unsigned CNT_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                                    r_state;
  state_t                                    w_next;
  logic [CNT_W-1:0]                          r_cnt;
  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] r_st_q;
  logic [15:0]                               r_perm_cnt;
  logic                                      w_in_ready;
  logic                                      w_accept;
  logic                                      w_handshake;

  // A new state can enter while idle, or while the finished result leaves.
  assign w_in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_handshake = (r_state == S_DONE) && bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: an accept in DONE goes straight back to RUN (no idle bubble)
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN:  if (r_cnt == LAST_STAGE) w_next = S_DONE;
      S_DONE: begin
        if (w_accept)           w_next = S_RUN;
        else if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Stage counter and input capture; counter returns to 0 after the last pass
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_st_q <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_st_q <= bus.in_state;
    end else if (r_state == S_RUN) begin
      r_cnt <= (r_cnt == LAST_STAGE) ? '0 : r_cnt + 1'b1;
    end
  end

  // Completed-permutation counter, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perm_cnt <= '0;
    end else if (w_handshake && (r_perm_cnt != '1)) begin
      r_perm_cnt <= r_perm_cnt + 16'd1;
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    stage_en      = 1'b0;
    perm_stage    = '0;
    stage_in      = r_st_q;
    bus.in_ready  = w_in_ready;
    bus.out_valid = 1'b0;
    bus.out_state = stage_out;
    busy          = (r_state != S_IDLE);
    perm_cnt      = r_perm_cnt;
    unique case (r_state)
      S_RUN: begin
        stage_en   = 1'b1;
        perm_stage = 32'(r_cnt);
        stage_in   = (r_cnt == '0) ? r_st_q : stage_out;
      end
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/perm_seq_ctrl.md
PERM_SEQ_CTRL -- requirements
Module: perm_seq_ctrl

Interface
REQ-001 SHALL have parameter X_AXIS, default 5, lane count in x.
REQ-002 SHALL have parameter Y_AXIS, default 5, lane count in y.
REQ-003 SHALL have parameter Z_AXIS, default 64, lane width in bits.
REQ-004 SHALL have parameter NUM_STAGES, default 8, stage passes per permutation (3 rounds each; 8 x 3 = 24 rounds).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1, an input state is offered.
REQ-008 SHALL have port in_ready, output, 1, the controller accepts an input state.
REQ-009 SHALL have port in_state, input, [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0], the state to permute.
REQ-010 SHALL have port out_valid, output, 1, the permuted state is available.
REQ-011 SHALL have port out_ready, output-side consumer input, 1, the consumer takes the result.
REQ-012 SHALL have port out_state, output, same shape as in_state, the permuted state.
REQ-013 SHALL have port stage_en, output, 1, the datapath stage register enable.
REQ-014 SHALL have port perm_stage, output, 32, the datapath stage index (round base = 3*perm_stage).
REQ-015 SHALL have port stage_in, output, state shape, the datapath stage input.
REQ-016 SHALL have port stage_out, input, state shape, the registered datapath stage output.
REQ-017 SHALL have port busy, output, 1, a permutation is in flight (RUN or DONE).
REQ-018 SHALL have port perm_cnt, output, 16, the number of completed permutations.

Function
REQ-019 SHALL implement three states: IDLE, RUN and DONE.
REQ-020 SHALL drive in_ready = 1 in IDLE, or in DONE when out_ready = 1; in_ready = 0 otherwise.
REQ-021 SHALL treat an accept as in_valid & in_ready at a rising edge, latch in_state into st_q, clear stage counter cnt to 0, and enter RUN.
REQ-022 In RUN, SHALL drive stage_en = 1, perm_stage = cnt zero-extended to 32 bits, and stage_in = st_q when cnt == 0, else stage_out.
REQ-023 In RUN, SHALL increment cnt every cycle; at cnt == NUM_STAGES-1 SHALL enter DONE on the next edge.
REQ-024 Outside RUN, SHALL drive stage_en = 0, perm_stage = 0 and stage_in = st_q.
REQ-025 In DONE, SHALL drive out_valid = 1 and out_state = stage_out; both are held stable until out_ready.
REQ-026 In DONE with out_ready = 1 and no accept, SHALL enter IDLE on the next edge.
REQ-027 In DONE with out_ready = 1 and an accept in the same cycle, SHALL go directly to RUN with cnt = 0 (back-to-back, no idle bubble).
REQ-028 SHALL give out_valid = 0 in IDLE and RUN; out_state is don't-care but SHALL equal stage_out.
REQ-029 Latency: if accept is at edge E0, out_valid SHALL rise after edge E0+NUM_STAGES (8 cycles) and out_state SHALL equal Keccak-f[1600](in_state).
REQ-030 SHALL ignore in_valid in RUN and in DONE without out_ready; in_state changes there SHALL NOT affect st_q.
REQ-031 SHALL increment perm_cnt on each out_valid & out_ready; SHALL saturate at 0xFFFF with no wrap.
REQ-032 SHALL drive busy = 1 in RUN and DONE, 0 in IDLE.
REQ-033 SHALL size cnt at $clog2(NUM_STAGES) bits; cnt SHALL never exceed NUM_STAGES-1.

Reset
REQ-034 While reset = 0, SHALL force state IDLE, cnt = 0, st_q = 0 and perm_cnt = 0, independent of clk.
REQ-035 Under reset, SHALL give outputs: in_ready = 1, out_valid = 0, stage_en = 0, perm_stage = 0, busy = 0, stage_in = 0.
REQ-036 Reset asserted mid-RUN or in DONE SHALL abort the permutation; no out_valid SHALL follow until a new accept.
REQ-037 Deassertion SHALL be synchronized externally; the first accept is legal on the first edge after release.

Verification
REQ-038 Zero state: accept all-zero in_state, out_ready = 1 -> out_valid rises exactly 8 cycles after accept; lane [0][0] = 0xF1258F7940E1DDE7; perm_cnt = 1.
REQ-039 Stage sequencing: single accept -> stage_en high 8 consecutive cycles; perm_stage = 0,1,...,7; stage_in = in_state only while perm_stage = 0.
REQ-040 Backpressure: hold out_ready = 0 for 20 cycles in DONE, toggling in_valid/in_state -> out_state stable, in_ready = 0, stage_en = 0; on release -> perm_cnt + 1.
REQ-041 Back-to-back: in_valid held high, out_ready = 1 -> results every 9 cycles, no IDLE cycle, each matches the golden model.
REQ-042 Reset mid-run: assert reset at perm_stage = 4 -> all outputs at reset values immediately; after release, a new zero-state accept -> same result as REQ-038.
REQ-043 Saturation: force 65536+ handshakes (or preload via test hook) -> perm_cnt holds 0xFFFF.
